// File: rtl/timeout_mon_mc.sv
// timeout_mon_mc: NCH independent reception-timeout channels with a busy window each,
// closed after to_limit idle cycles. Define TIMEOUT_STATS_EN to build per-channel timeout counters.
module timeout_mon_mc #(
  parameter int NCH         = 4,
  parameter int TOCNTSIZE   = 7,
  parameter int STATCNTSIZE = 8,
  parameter int SELW        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         received,
  input  logic [TOCNTSIZE-1:0]   to_limit,
  input  logic [NCH-1:0]         to_ack,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         timeout,
  output logic [NCH-1:0]         to_flag,
  output logic                   any_busy,
  input  logic [SELW-1:0]        stat_sel,
  input  logic                   stat_clr,
  output logic [STATCNTSIZE-1:0] stat_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e               state_q [NCH];
  state_e               state_d [NCH];
  logic [TOCNTSIZE-1:0] cnt_q   [NCH];
  logic [TOCNTSIZE-1:0] cnt_d   [NCH];
  logic [TOCNTSIZE:0]   cnt_inc [NCH];
  logic [TOCNTSIZE-1:0] lim;
  logic [NCH-1:0]       timeout_q, timeout_d;
  logic [NCH-1:0]       to_flag_q, to_flag_d;

  assign lim = (to_limit == '0) ? TOCNTSIZE'(1) : to_limit;

  // The extra sum bit keeps the limit compare from wrapping when to_limit is all-ones.
  always_comb begin
    timeout_d = '0;
    to_flag_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      cnt_inc[i] = {1'b0, cnt_q[i]} + (TOCNTSIZE+1)'(1);
      if (state_q[i] == ST_IDLE) begin
        if (received[i]) state_d[i] = ST_BUSY;
      end else if (!received[i]) begin
        if (cnt_inc[i] >= {1'b0, lim}) begin
          state_d[i]   = ST_IDLE;
          timeout_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_inc[i][TOCNTSIZE-1:0];
        end
      end
      to_flag_d[i] = timeout_d[i] | (to_flag_q[i] & ~to_ack[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      timeout_q <= '0;
      to_flag_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      timeout_q <= timeout_d;
      to_flag_q <= to_flag_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) busy[i] = (state_q[i] == ST_BUSY);
  end

  assign any_busy = |busy;
  assign timeout  = timeout_q;
  assign to_flag  = to_flag_q;

`ifdef TIMEOUT_STATS_EN
  logic [STATCNTSIZE-1:0] stat_q [NCH];
  logic [STATCNTSIZE-1:0] stat_d [NCH];
  logic [STATCNTSIZE-1:0] stat_cnt_q, stat_cnt_d;

  // A clear coinciding with an event leaves the count at 1; readback shows the pre-update value.
  always_comb begin
    stat_cnt_d = '0;
    for (int k = 0; k < NCH; k++) begin
      stat_d[k] = stat_q[k];
      if (timeout_d[k]) begin
        if (stat_clr && (int'(stat_sel) == k)) stat_d[k] = STATCNTSIZE'(1);
        else if (!(&stat_q[k]))                stat_d[k] = stat_q[k] + STATCNTSIZE'(1);
      end else if (stat_clr && (int'(stat_sel) == k)) begin
        stat_d[k] = '0;
      end
      if (int'(stat_sel) == k) stat_cnt_d = stat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) stat_q[k] <= '0;
      stat_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) stat_q[k] <= stat_d[k];
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = ^{stat_sel, stat_clr};
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_timeout_mon_mc.sv
// tb_timeout_mon_mc: randomized and directed stimulus for timeout_mon_mc, checked against
// a model that tracks the edge number of each channel's last strobe.
module tb_timeout_mon_mc;
  localparam int NCH         = 4;
  localparam int TOCNTSIZE   = 7;
  localparam int STATCNTSIZE = 8;
  localparam int SELW        = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCH-1:0]         received;
  logic [TOCNTSIZE-1:0]   to_limit;
  logic [NCH-1:0]         to_ack;
  logic [NCH-1:0]         busy, timeout, to_flag;
  logic                   any_busy;
  logic [SELW-1:0]        stat_sel;
  logic                   stat_clr;
  logic [STATCNTSIZE-1:0] stat_cnt;

  always #5 clk = ~clk;

  timeout_mon_mc #(
    .NCH(NCH), .TOCNTSIZE(TOCNTSIZE), .STATCNTSIZE(STATCNTSIZE), .SELW(SELW)
  ) dut (
    .clk(clk), .rst(rst), .received(received), .to_limit(to_limit), .to_ack(to_ack),
    .busy(busy), .timeout(timeout), .to_flag(to_flag), .any_busy(any_busy),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  int checks = 0;
  int failures = 0;

  int edge_num = 0;
  int last_rx [NCH];
  bit m_busy  [NCH];
  bit m_to    [NCH];
  bit m_flag  [NCH];
  int m_stat  [NCH];
  int m_stat_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_num, got, exp);
    end
  endtask

  // A busy channel closes once the edges elapsed since its last strobe reach the live limit.
  function automatic void modelEdge();
    int lim;
    int stat_max;
    bit clr_hit;
    lim = (to_limit == 0) ? 1 : int'(to_limit);
    stat_max = (1 << STATCNTSIZE) - 1;
    edge_num++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_busy[i] = 0; m_to[i] = 0; m_flag[i] = 0; m_stat[i] = 0;
      end
      m_stat_cnt = 0;
      return;
    end
    m_stat_cnt = (int'(stat_sel) < NCH) ? m_stat[int'(stat_sel)] : 0;
    for (int i = 0; i < NCH; i++) begin
      m_to[i] = 0;
      if (received[i]) begin
        m_busy[i] = 1;
        last_rx[i] = edge_num;
      end else if (m_busy[i] && (edge_num - last_rx[i] >= lim)) begin
        m_busy[i] = 0;
        m_to[i] = 1;
      end
      if (m_to[i]) m_flag[i] = 1;
      else if (to_ack[i]) m_flag[i] = 0;
      clr_hit = stat_clr && (int'(stat_sel) == i);
      if (m_to[i] && clr_hit) m_stat[i] = 1;
      else if (m_to[i]) m_stat[i] = (m_stat[i] >= stat_max) ? stat_max : m_stat[i] + 1;
      else if (clr_hit) m_stat[i] = 0;
    end
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] rx, input int lim, input logic [NCH-1:0] ack,
                               input int sel, input bit clr, input bit r);
    logic [NCH-1:0] eb, et, ef;
    int exp_stat;
    received = rx;
    to_limit = TOCNTSIZE'(lim);
    to_ack   = ack;
    stat_sel = SELW'(sel);
    stat_clr = clr;
    rst      = r;
    @(posedge clk);
    modelEdge();
    #1;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = m_busy[i]; et[i] = m_to[i]; ef[i] = m_flag[i];
    end
`ifdef TIMEOUT_STATS_EN
    exp_stat = m_stat_cnt;
`else
    exp_stat = 0;
`endif
    checkOutput("busy", 32'(busy), 32'(eb));
    checkOutput("timeout", 32'(timeout), 32'(et));
    checkOutput("to_flag", 32'(to_flag), 32'(ef));
    checkOutput("any_busy", 32'(any_busy), 32'(|eb));
    checkOutput("stat_cnt", 32'(stat_cnt), 32'(exp_stat));
  endtask

  task automatic idleCycles(input int n, input int lim);
    for (int k = 0; k < n; k++) applyStimulus('0, lim, '0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) last_rx[i] = 0;
    received = '0; to_limit = '0; to_ack = '0; stat_sel = '0; stat_clr = 1'b0; rst = 1'b1;

    for (int k = 0; k < 3; k++) applyStimulus('0, 5, '0, 0, 1'b0, 1'b1);

    // Single strobe on ch0, limit 5: busy for five edges, then timeout pulse and flag.
    applyStimulus(4'b0001, 5, '0, 0, 1'b0, 1'b0);
    idleCycles(8, 5);
    applyStimulus('0, 5, 4'b0001, 0, 1'b0, 1'b0);

    // ch1 strobes every 4 cycles keep the window open, then it expires.
    for (int n = 0; n < 10; n++) begin
      applyStimulus(4'b0010, 5, '0, 1, 1'b0, 1'b0);
      idleCycles(3, 5);
    end
    idleCycles(7, 5);

    // Strobe landing on the limit edge restarts the window.
    applyStimulus(4'b0100, 5, '0, 2, 1'b0, 1'b0);
    idleCycles(4, 5);
    applyStimulus(4'b0100, 5, '0, 2, 1'b0, 1'b0);
    idleCycles(7, 5);

    // to_limit 0 behaves as 1; timeout and ack on the same edge keeps the flag.
    applyStimulus(4'b1000, 0, '0, 3, 1'b0, 1'b0);
    applyStimulus('0, 0, 4'b1000, 3, 1'b0, 1'b0);
    applyStimulus('0, 0, 4'b1000, 3, 1'b0, 1'b0);

    // Maximum limit, no wrap.
    applyStimulus(4'b0001, 127, '0, 0, 1'b0, 1'b0);
    idleCycles(130, 127);

    // Lowering the limit mid-window fires on the next idle edge.
    applyStimulus(4'b0010, 20, '0, 1, 1'b0, 1'b0);
    idleCycles(6, 20);
    idleCycles(2, 3);

    // Reset mid-window.
    applyStimulus(4'b1111, 6, '0, 0, 1'b0, 1'b0);
    idleCycles(2, 6);
    applyStimulus('0, 6, '0, 0, 1'b0, 1'b1);
    idleCycles(3, 6);

    // Stat clear on a channel, with and without a coinciding timeout.
    applyStimulus(4'b0100, 2, '0, 2, 1'b0, 1'b0);
    applyStimulus('0, 2, '0, 2, 1'b0, 1'b0);
    applyStimulus('0, 2, '0, 2, 1'b1, 1'b0);
    applyStimulus('0, 2, '0, 2, 1'b0, 1'b0);

    for (int n = 0; n < 2500; n++) begin
      logic [NCH-1:0] rx, ack;
      int lim;
      for (int i = 0; i < NCH; i++) rx[i] = ($urandom_range(0, 5) == 0);
      ack = NCH'($urandom_range(0, 15)) & NCH'($urandom_range(0, 15));
      lim = ($urandom_range(0, 30) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 9));
      applyStimulus(rx, lim, ack, int'($urandom_range(0, NCH-1)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
